// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core.
// Frame: start, 8 data bits LSB-first, even parity, stop.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 20;
    localparam int DATA_BITS = 8;
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_BITS,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter; tick marks the end of each period.
// start reloads it with a full or half period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic half,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

    logic [W-1:0] cnt;

    // Count down, auto-reloading a full period after each tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= half ? HALF : FULL;
        end else if (cnt == '0) begin
            cnt <= FULL;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !start;

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: 8 data bits, caller/even parity, 1 stop.
// RX and TX run independently, each with its own bit timer.
module uart_core #(
    parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_reset_ready,
    output logic       rx_error,
    input  logic [8:0] tx_data,
    input  logic       tx_send,
    output logic       tx_busy
);

    import uart_pkg::*;

    logic rx_meta, rx_sync, rx_prev;
    rx_state_t rx_state, rx_state_n;
    logic [7:0] rx_shreg, rx_shreg_n, rx_data_n;
    logic [3:0] rx_cnt, rx_cnt_n;
    logic rx_par, rx_par_n, rx_error_n, rx_ready_n;
    logic rx_tmr_start, rx_tmr_half, rx_tick;

    tx_state_t tx_state, tx_state_n;
    logic [8:0] tx_shreg, tx_shreg_n;
    logic [3:0] tx_cnt, tx_cnt_n;
    logic tx_o_n, tx_busy_n, tx_tmr_start, tx_tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk(clk), .reset(reset), .start(rx_tmr_start),
        .half(rx_tmr_half), .tick(rx_tick)
    );

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk(clk), .reset(reset), .start(tx_tmr_start),
        .half(1'b0), .tick(tx_tick)
    );

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {rx_prev, rx_sync, rx_meta} <= 3'b111;
        end else begin
            {rx_prev, rx_sync, rx_meta} <= {rx_sync, rx_meta, rx_i};
        end
    end

    // Receiver next-state and datapath.
    always_comb begin
        rx_state_n   = rx_state;
        rx_shreg_n   = rx_shreg;
        rx_cnt_n     = rx_cnt;
        rx_par_n     = rx_par;
        rx_data_n    = rx_data;
        rx_error_n   = rx_error;
        rx_ready_n   = rx_ready;
        rx_tmr_start = 1'b0;
        rx_tmr_half  = 1'b0;
        if (rx_reset_ready) rx_ready_n = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_tmr_start = 1'b1;
                    rx_tmr_half  = 1'b1;
                    rx_state_n   = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shreg_n = {rx_sync, rx_shreg[7:1]};
                    rx_cnt_n   = rx_cnt + 1'b1;
                    if (rx_cnt == 4'(DATA_BITS - 1)) rx_state_n = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_par_n   = rx_sync;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_sync) begin
                        rx_data_n  = rx_shreg;
                        rx_error_n = ^rx_shreg ^ rx_par;
                        rx_ready_n = 1'b1;
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_shreg <= '0;
            rx_cnt   <= '0;
            rx_par   <= 1'b0;
            rx_data  <= '0;
            rx_error <= 1'b0;
            rx_ready <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_shreg <= rx_shreg_n;
            rx_cnt   <= rx_cnt_n;
            rx_par   <= rx_par_n;
            rx_data  <= rx_data_n;
            rx_error <= rx_error_n;
            rx_ready <= rx_ready_n;
        end
    end

    // Transmitter next-state; line level derived from the next state.
    always_comb begin
        tx_state_n   = tx_state;
        tx_shreg_n   = tx_shreg;
        tx_cnt_n     = tx_cnt;
        tx_tmr_start = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                if (tx_send) begin
                    tx_shreg_n   = tx_data;
                    tx_tmr_start = 1'b1;
                    tx_state_n   = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_cnt_n   = '0;
                    tx_state_n = TX_BITS;
                end
            end
            TX_BITS: begin
                if (tx_tick) begin
                    tx_shreg_n = {1'b0, tx_shreg[8:1]};
                    tx_cnt_n   = tx_cnt + 1'b1;
                    if (tx_cnt == 4'(DATA_BITS)) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_tick) tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        tx_busy_n = (tx_state_n != TX_IDLE);
        if (tx_state_n == TX_START) begin
            tx_o_n = 1'b0;
        end else if (tx_state_n == TX_BITS) begin
            tx_o_n = tx_shreg_n[0];
        end else begin
            tx_o_n = 1'b1;
        end
    end

    // Transmitter state and registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_shreg <= '0;
            tx_cnt   <= '0;
            tx_o     <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_shreg <= tx_shreg_n;
            tx_cnt   <= tx_cnt_n;
            tx_o     <= tx_o_n;
            tx_busy  <= tx_busy_n;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: RX frames, parity/framing errors,
// TX waveform and busy rules, mid-frame reset, concurrent RX/TX.
module tb_uart_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_i = 1'b1;
    logic       tx_o;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_reset_ready = 1'b0;
    logic       rx_error;
    logic [8:0] tx_data = '0;
    logic       tx_send = 1'b0;
    logic       tx_busy;

    int total = 0;
    int bad = 0;

    logic [8:0] rxq[$];
    logic       txq[$];

    uart_core #(.CLKS_PER_BIT(20)) dut (
        .clk(clk), .reset(reset), .rx_i(rx_i), .tx_o(tx_o),
        .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_reset_ready(rx_reset_ready), .rx_error(rx_error),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic p,
                           input logic s);
        if (s) rxq.push_back({^d ^ p, d});
        rx_i = 1'b0;
        wait_cyc(20);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            wait_cyc(20);
        end
        rx_i = p;
        wait_cyc(20);
        rx_i = s;
        wait_cyc(20);
        rx_i = 1'b1;
    endtask

    task automatic rx_expect();
        logic [8:0] e;
        for (int k = 0; k < 60 && rx_ready !== 1'b1; k++) @(negedge clk);
        chk("rx_ready_set", rx_ready, 1);
        chk("rx_queue_nonempty", rxq.size(), 1);
        if (rxq.size() > 0) begin
            e = rxq.pop_front();
            chk("rx_data", rx_data, e[7:0]);
            chk("rx_error", rx_error, e[8]);
        end
    endtask

    task automatic rx_clear();
        rx_reset_ready = 1'b1;
        @(negedge clk);
        rx_reset_ready = 1'b0;
        chk("rx_ready_cleared", rx_ready, 0);
    endtask

    task automatic tx_frame(input logic [8:0] d, input bit poke);
        int k;
        int busy_cnt;
        logic e;
        txq.push_back(1'b0);
        for (int i = 0; i < 9; i++) txq.push_back(d[i]);
        txq.push_back(1'b1);
        tx_data = d;
        tx_send = 1'b1;
        @(negedge clk);
        tx_send = 1'b0;
        k = 0;
        while (tx_o !== 1'b0 && k < 5) begin
            @(negedge clk);
            k++;
        end
        chk("tx_start_seen", tx_o, 0);
        chk("tx_busy_with_start", tx_busy, 1);
        busy_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (tx_busy !== 1'b1) break;
            busy_cnt++;
            if (c % 20 == 10 && txq.size() > 0) begin
                e = txq.pop_front();
                chk($sformatf("tx_bit%0d", c / 20), tx_o, e);
            end
            tx_send = poke && (c == 100);
            if (poke && c == 100) tx_data = 9'h0FF;
            @(negedge clk);
        end
        tx_send = 1'b0;
        chk("tx_busy_cycles", busy_cnt, 220);
        chk("tx_bits_left", txq.size(), 0);
        chk("tx_idle_high", tx_o, 1);
    endtask

    initial begin
        wait_cyc(3);
        chk("rst_tx_o", tx_o, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_error", rx_error, 0);
        reset = 1'b1;
        wait_cyc(5);

        send_rx(8'h1D, 1'b0, 1'b1);
        rx_expect();
        rx_clear();

        send_rx(8'h1D, 1'b1, 1'b1);
        rx_expect();
        rx_clear();

        rx_i = 1'b0;
        wait_cyc(5);
        rx_i = 1'b1;
        wait_cyc(60);
        chk("glitch_no_ready", rx_ready, 0);

        send_rx(8'h1D, 1'b0, 1'b0);
        wait_cyc(40);
        chk("framing_no_ready", rx_ready, 0);
        send_rx(8'h5A, 1'b0, 1'b1);
        rx_expect();

        tx_frame(9'h157, 1'b0);
        wait_cyc(5);
        tx_frame(9'h0C3, 1'b1);
        wait_cyc(30);
        chk("poke_dropped_busy", tx_busy, 0);
        chk("poke_dropped_line", tx_o, 1);
        tx_frame(9'h0A5, 1'b0);
        tx_frame(9'h13C, 1'b0);

        tx_data = 9'h0AA;
        tx_send = 1'b1;
        rx_i = 1'b0;
        @(negedge clk);
        tx_send = 1'b0;
        wait_cyc(19);
        for (int i = 0; i < 4; i++) begin
            rx_i = i[0];
            wait_cyc(20);
        end
        rx_i = 1'b1;
        wait_cyc(10);
        chk("pre_rst_tx_busy", tx_busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_tx_o", tx_o, 1);
        chk("mid_rst_tx_busy", tx_busy, 0);
        chk("mid_rst_rx_ready", rx_ready, 0);
        wait_cyc(3);
        rx_i = 1'b1;
        reset = 1'b1;
        wait_cyc(300);
        chk("post_rst_rx_ready", rx_ready, 0);
        chk("post_rst_tx_o", tx_o, 1);
        send_rx(8'hC3, 1'b0, 1'b1);
        rx_expect();
        rx_clear();

        fork
            tx_frame(9'h1E7, 1'b0);
            begin
                wait_cyc(7);
                send_rx(8'h96, 1'b1, 1'b1);
                rx_expect();
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_core.md
# uart_core

Full-duplex UART with a fixed frame format: 1 start bit, 8 data bits LSB-first, 1 even-parity bit and 1 stop bit. The receiver decodes the serial line `rx_i` into a byte with a sticky ready flag. The transmitter serialises a caller-supplied 9-bit word (data plus parity) onto `tx_o`. The block sits between the board serial pins and the host-side logic.

## Interface
- `CLKS_PER_BIT`, default 20: clock cycles per serial bit (20 ns clk gives a 400 ns bit).
- `clk`  in  1: single system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `rx_i`  in  1: serial input, idles high.
- `tx_o`  out  1: serial output, idles high.
- `rx_data`  out  8: last received byte.
- `rx_ready`  out  1: sticky flag, a new byte is valid.
- `rx_reset_ready`  in  1: level; clears `rx_ready`.
- `rx_error`  out  1: last frame had a parity error; valid while `rx_ready` is high.
- `tx_data`  in  9: `[7:0]` payload, `[8]` parity bit, sent verbatim.
- `tx_send`  in  1: single-cycle start request.
- `tx_busy`  out  1: transmitter occupied.

## Operation
- Reset values: `tx_o`=1, `tx_busy`=0, `rx_ready`=0, `rx_data`=0, `rx_error`=0. Both FSMs go to IDLE and counters clear.
- `rx_i` passes through a 2-flop synchroniser before any use.
- Receiver FSM:
  - IDLE: on a synchronised falling edge, go to START.
  - START: wait `CLKS_PER_BIT/2`. If the line is still low, go to DATA; otherwise return to IDLE (glitch rejected).
  - DATA: sample every `CLKS_PER_BIT` (mid-bit). Shift bits LSB-first; 8 samples.
  - PARITY: take one sample.
  - STOP: take one sample.
    - If high: load `rx_data`, set `rx_error` = (XOR of 8 data bits XOR parity bit), set `rx_ready`, then go to IDLE.
    - If low (framing error): discard the frame, leave `rx_ready`/`rx_data` unchanged, wait for the line to return high, then go to IDLE.
- `rx_ready` stays high until `rx_reset_ready` is sampled high. A new frame arriving while `rx_ready`=1 overwrites `rx_data`/`rx_error`.
- If frame completion and `rx_reset_ready` occur in the same cycle, completion wins and `rx_ready` stays 1.
- Transmitter FSM:
  - IDLE: `tx_send`=1 latches `tx_data` and goes to START.
  - START: `tx_o`=0 for one bit.
  - BITS: send `tx_data[0..8]` LSB-first, one bit each.
  - STOP: `tx_o`=1 for one bit, then go to IDLE.
- `tx_send` while `tx_busy`=1 is ignored; the request is dropped, not queued.
- Changing `tx_data` after the latch has no effect on the frame in flight.

## Timing
- Every bit lasts exactly `CLKS_PER_BIT` cycles.
- TX frame = 11 bit times (220 cycles at default).
- `tx_o` falls and `tx_busy` rises on the first clock edge after the edge that samples `tx_send`.
- `tx_busy` falls on the same edge that ends the stop bit, so back-to-back `tx_send` is accepted on the next cycle.
- RX samples mid-bit, 2 cycles late (synchroniser delay). This tolerates up to about ±4% rate mismatch.
- `rx_ready` rises one cycle after the stop-bit sample, i.e. about 10.5 bit times + 3 cycles after the start edge.
- `rx_reset_ready` clears `rx_ready` on the next edge.
- Reset asserted mid-frame aborts immediately:
  - `tx_o` returns to 1.
  - Partial RX data is discarded.
- Receiver and transmitter are fully independent; simultaneous RX and TX are required to work.

## Structure
- Package `uart_pkg`:
  - `CLKS_PER_BIT` default.
  - `DATA_BITS`=8, `FRAME_BITS`=11.
  - Enums `rx_state_t` (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE) and `tx_state_t` (IDLE, START, BITS, STOP).
- One sub-module, `uart_bit_timer`: a bit-period counter with a load-half option and a `tick` output. It is instantiated once in the RX path and once in the TX path.
- FSMs, shift registers and the synchroniser live in `uart_core`.

## Test plan
- RX good frame: start, bits 1,0,1,1,1,0,0,0, parity 0, stop 1, at 400 ns per bit → `rx_data`=0x1D, `rx_error`=0, `rx_ready`=1. Pulse `rx_reset_ready` → `rx_ready`=0 on the next cycle.
- RX parity error: same frame with parity 1 → `rx_data`=0x1D, `rx_error`=1, `rx_ready`=1.
- RX glitch and framing error:
  - 5-cycle low pulse on idle `rx_i` → no `rx_ready`, `rx_i` idle high afterwards.
  - Frame with stop bit 0 → `rx_ready` stays 0.
- TX: `tx_data`=9'h157, `tx_send` for 1 cycle → `tx_o` = 0,1,1,1,0,1,0,1,0,1,1 at 20 cycles each; `tx_busy` high for exactly 220 cycles.
- TX busy: second `tx_send` mid-frame → ignored; only one frame sent. `tx_send` on the cycle after `tx_busy` falls → second frame starts.
- Reset mid-frame: assert `reset` low during TX bit 4 and RX bit 4 → `tx_o`=1, `tx_busy`=0, `rx_ready`=0 immediately. A clean frame afterwards is received correctly.
